zap_tlb_walker: RTL and testbench

//  Hardware page-table walker for the ZAP MMU. Consumes the TLB-check walk request
//  (VA that missed all four TLBs) and fetches L1 and, if needed, L2 descriptors over
//  a Wishbone-style read port. Produces either one TLB refill (section, large, small
//  or fine page) or a translation / external-abort fault with FSR and FAR.

---
 rtl/zap_tlb_walker.sv | 226 ++++++++++++++++++++++
 tb/tb_zap_tlb_walker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_tlb_walker.sv
// ZAP MMU hardware page-table walker: fetches L1/L2 descriptors over a Wishbone
// read port and produces a single TLB refill or a translation/external-abort fault.
module zap_tlb_walker #(
  parameter logic [31:0] BUS_TIMEOUT = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_walk,
  input  logic [31:0] i_va,
  input  logic [31:0] i_ttbr,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [31:0] o_wb_adr,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_dat,
  output logic [3:0]  o_tlb_wsel,
  output logic [31:0] o_tlb_wva,
  output logic [31:0] o_tlb_wdesc,
  output logic [3:0]  o_tlb_wdom,
  output logic        o_done,
  output logic        o_fault,
  output logic [7:0]  o_fsr,
  output logic [31:0] o_far
);

  typedef enum logic [1:0] {IDLE, L1_RD, L2_RD, DONE} state_t;

  localparam logic [31:0] TMO_LAST = BUS_TIMEOUT - 32'd1;

  state_t      state_q, state_d;
  logic [31:0] va_q, va_d, adr_q, adr_d, tmo_q, tmo_d, wdesc_q, wdesc_d;
  logic [3:0]  dom_q, dom_d, wdom_q, wdom_d, wsel_q, wsel_d;
  logic [7:0]  fsr_q, fsr_d;
  logic        fine_q, fine_d, stb_q, stb_d, flush_q, flush_d, fault_q, fault_d;
  logic        tmo_hit, ends, abort;
  logic        go_fault, go_refill;
  logic [7:0]  f_fsr;
  logic [3:0]  r_sel, r_dom;
  logic        unused_ttbr;

  assign unused_ttbr = ^i_ttbr[13:0];

  assign tmo_hit = stb_q && !i_wb_ack && !i_wb_err &&
                   (BUS_TIMEOUT != 32'd0) && (tmo_q == TMO_LAST);
  assign ends    = stb_q && (i_wb_ack || i_wb_err || tmo_hit);
  assign abort   = i_wb_err || tmo_hit;

  always_comb begin
    state_d   = state_q;
    va_d      = va_q;
    adr_d     = adr_q;
    tmo_d     = tmo_q;
    dom_d     = dom_q;
    fine_d    = fine_q;
    stb_d     = stb_q;
    flush_d   = flush_q;
    fault_d   = fault_q;
    fsr_d     = fsr_q;
    wsel_d    = wsel_q;
    wdesc_d   = wdesc_q;
    wdom_d    = wdom_q;
    go_fault  = 1'b0;
    go_refill = 1'b0;
    f_fsr     = '0;
    r_sel     = '0;
    r_dom     = '0;

    unique case (state_q)
      IDLE: begin
        if (i_walk) begin
          va_d    = i_va;
          adr_d   = {i_ttbr[31:14], i_va[31:20], 2'b00};
          stb_d   = 1'b1;
          tmo_d   = '0;
          flush_d = 1'b0;
          state_d = L1_RD;
        end
      end
      L1_RD, L2_RD: begin
        if (i_flush) flush_d = 1'b1;
        if (!stb_q) begin
          // Idle gap between the L1 and L2 strobes; nothing outstanding to wait for.
          if (i_flush) state_d = IDLE;
          else begin
            stb_d = 1'b1;
            tmo_d = '0;
          end
        end else if (ends) begin
          stb_d = 1'b0;
          if (flush_q || i_flush) state_d = IDLE;
          else if (state_q == L1_RD) begin
            if (abort) begin
              go_fault = 1'b1;
              f_fsr    = 8'h0C;
            end else begin
              unique case (i_wb_dat[1:0])
                2'b00: begin
                  go_fault = 1'b1;
                  f_fsr    = 8'h05;
                end
                2'b10: begin
                  go_refill = 1'b1;
                  r_sel     = 4'b0100;
                  r_dom     = i_wb_dat[8:5];
                end
                2'b01: begin
                  dom_d   = i_wb_dat[8:5];
                  fine_d  = 1'b0;
                  adr_d   = {i_wb_dat[31:10], va_q[19:12], 2'b00};
                  state_d = L2_RD;
                end
                default: begin
                  dom_d   = i_wb_dat[8:5];
                  fine_d  = 1'b1;
                  adr_d   = {i_wb_dat[31:12], va_q[19:10], 2'b00};
                  state_d = L2_RD;
                end
              endcase
            end
          end else begin
            r_dom = dom_q;
            if (abort) begin
              go_fault = 1'b1;
              f_fsr    = {dom_q, 4'hE};
            end else begin
              unique case (i_wb_dat[1:0])
                2'b00: begin
                  go_fault = 1'b1;
                  f_fsr    = {dom_q, 4'h7};
                end
                2'b01: begin
                  go_refill = 1'b1;
                  r_sel     = 4'b0010;
                end
                2'b10: begin
                  go_refill = 1'b1;
                  r_sel     = 4'b0001;
                end
                default: begin
                  if (fine_q) begin
                    go_refill = 1'b1;
                    r_sel     = 4'b1000;
                  end else begin
                    go_fault = 1'b1;
                    f_fsr    = {dom_q, 4'h7};
                  end
                end
              endcase
            end
          end
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go_fault) begin
      state_d = DONE;
      fault_d = 1'b1;
      fsr_d   = f_fsr;
      wsel_d  = '0;
    end
    if (go_refill) begin
      state_d = DONE;
      fault_d = 1'b0;
      wsel_d  = r_sel;
      wdesc_d = i_wb_dat;
      wdom_d  = r_dom;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      va_q    <= '0;
      adr_q   <= '0;
      tmo_q   <= '0;
      dom_q   <= '0;
      fine_q  <= 1'b0;
      stb_q   <= 1'b0;
      flush_q <= 1'b0;
      fault_q <= 1'b0;
      fsr_q   <= '0;
      wsel_q  <= '0;
      wdesc_q <= '0;
      wdom_q  <= '0;
    end else begin
      state_q <= state_d;
      va_q    <= va_d;
      adr_q   <= adr_d;
      tmo_q   <= tmo_d;
      dom_q   <= dom_d;
      fine_q  <= fine_d;
      stb_q   <= stb_d;
      flush_q <= flush_d;
      fault_q <= fault_d;
      fsr_q   <= fsr_d;
      wsel_q  <= wsel_d;
      wdesc_q <= wdesc_d;
      wdom_q  <= wdom_d;
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_wb_cyc    = stb_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_adr    = adr_q;
  assign o_wb_we     = 1'b0;
  assign o_wb_sel    = {4{stb_q}};
  assign o_done      = (state_q == DONE) && !i_flush;
  assign o_tlb_wsel  = o_done ? wsel_q : '0;
  assign o_tlb_wva   = va_q;
  assign o_tlb_wdesc = wdesc_q;
  assign o_tlb_wdom  = wdom_q;
  assign o_fault     = fault_q;
  assign o_fsr       = fsr_q;
  assign o_far       = va_q;

endmodule

// File: tb/tb_zap_tlb_walker.sv
// Bench for zap_tlb_walker: directed cases plus randomized walks against a
// descriptor-level reference model, with a cycle-accurate Wishbone slave.
module tb_zap_tlb_walker;

  localparam int BT = 8;

  logic        i_clk, i_reset, i_walk, i_flush, i_wb_ack, i_wb_err;
  logic [31:0] i_va, i_ttbr, i_wb_dat;
  logic        o_busy, o_wb_cyc, o_wb_stb, o_wb_we, o_done, o_fault;
  logic [31:0] o_wb_adr, o_tlb_wva, o_tlb_wdesc, o_far;
  logic [3:0]  o_wb_sel, o_tlb_wsel, o_tlb_wdom;
  logic [7:0]  o_fsr;

  int checks = 0;
  int errors = 0;

  zap_tlb_walker #(.BUS_TIMEOUT(32'd8)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_walk(i_walk), .i_va(i_va), .i_ttbr(i_ttbr),
    .i_flush(i_flush), .o_busy(o_busy), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_adr(o_wb_adr), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack),
    .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat), .o_tlb_wsel(o_tlb_wsel), .o_tlb_wva(o_tlb_wva),
    .o_tlb_wdesc(o_tlb_wdesc), .o_tlb_wdom(o_tlb_wdom), .o_done(o_done), .o_fault(o_fault),
    .o_fsr(o_fsr), .o_far(o_far)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Bus response modes: 0 ack, 1 err, 2 ack+err, 3 no response (timeout)
  typedef struct {
    bit          fault;
    logic [7:0]  fsr;
    logic [3:0]  wsel;
    logic [31:0] wdesc;
    logic [3:0]  wdom;
    int          lat;
    int          nrd;
    logic [31:0] a1;
    logic [31:0] a2;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] va, ttbr, l1, l2,
                                 input int d1, m1, d2, m2);
    exp_t e;
    logic [3:0] dom;
    e.fault = 0; e.fsr = 0; e.wsel = 0; e.wdesc = 0; e.wdom = 0;
    e.nrd = 1; e.a2 = 0;
    e.a1 = (ttbr & 32'hFFFF_C000) + ((va >> 20) * 4);
    if (m1 == 3) begin
      e.fault = 1; e.fsr = 8'h0C; e.lat = 1 + BT; return e;
    end
    e.lat = 2 + d1;
    if (m1 != 0) begin
      e.fault = 1; e.fsr = 8'h0C; return e;
    end
    if (l1[1:0] == 2'b00) begin
      e.fault = 1; e.fsr = 8'h05; return e;
    end
    if (l1[1:0] == 2'b10) begin
      e.wsel = 4'b0100; e.wdesc = l1; e.wdom = l1[8:5]; return e;
    end
    dom = l1[8:5];
    e.nrd = 2;
    if (l1[1:0] == 2'b01) e.a2 = (l1 & 32'hFFFF_FC00) + (((va >> 12) & 32'hFF) * 4);
    else                  e.a2 = (l1 & 32'hFFFF_F000) + (((va >> 10) & 32'h3FF) * 4);
    if (m2 == 3) begin
      e.fault = 1; e.fsr = {dom, 4'hE}; e.lat = 3 + d1 + BT; return e;
    end
    e.lat = 4 + d1 + d2;
    if (m2 != 0) begin
      e.fault = 1; e.fsr = {dom, 4'hE}; return e;
    end
    if (l2[1:0] == 2'b00 || (l2[1:0] == 2'b11 && l1[1:0] == 2'b01)) begin
      e.fault = 1; e.fsr = {dom, 4'h7}; return e;
    end
    e.wsel  = (l2[1:0] == 2'b01) ? 4'b0010 : (l2[1:0] == 2'b10) ? 4'b0001 : 4'b1000;
    e.wdesc = l2;
    e.wdom  = dom;
    return e;
  endfunction

  function automatic int pick_mode();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 1;
    if (r == 1) return 2;
    if (r == 2) return 3;
    return 0;
  endfunction

  // flush_cyc < 0: no flush; 0: flush with the request; >0: flush in that cycle.
  task automatic run_walk(input logic [31:0] va, ttbr, l1, l2, input int d1, m1, d2, m2,
                          input int flush_cyc, output bit got_done, output int got_cyc,
                          output bit wsel_seen);
    exp_t e;
    logic [31:0] cur_adr, g_wdesc, g_far;
    logic [7:0]  g_fsr;
    logic [3:0]  g_wsel, g_wdom;
    bit          responded, prev_stb, fin, g_fault;
    int          rd, cnt, d, m;
    e = model(va, ttbr, l1, l2, d1, m1, d2, m2);
    @(negedge i_clk);
    i_walk = 1; i_va = va; i_ttbr = ttbr; i_flush = (flush_cyc == 0);
    i_wb_ack = 0; i_wb_err = 0;
    rd = -1; cnt = 0; responded = 0; prev_stb = 0; fin = 0; cur_adr = 0;
    got_done = 0; got_cyc = 0; wsel_seen = 0;
    g_fault = 0; g_fsr = 0; g_wsel = 0; g_wdesc = 0; g_wdom = 0; g_far = 0;
    for (int c = 1; c <= 64 && !fin; c++) begin
      @(negedge i_clk);
      i_walk = 0; i_wb_ack = 0; i_wb_err = 0; i_wb_dat = $urandom;
      i_flush = (c == flush_cyc);
      if (o_wb_stb) begin
        if (!prev_stb) begin
          rd++; cnt = 0; responded = 0; cur_adr = o_wb_adr;
          if (rd == 0) chk("adr_l1", o_wb_adr, e.a1);
          else if (rd == 1) chk("adr_l2", o_wb_adr, e.a2);
          else chk("read_count", rd, 1);
          chk("bus_ctl", {o_wb_cyc, o_wb_we, o_wb_sel}, 6'b1_0_1111);
        end else begin
          chk("adr_hold", o_wb_adr, cur_adr);
          if (responded) chk("stb_drop", o_wb_stb, 0);
        end
        d = (rd == 0) ? d1 : d2;
        m = (rd == 0) ? m1 : m2;
        if (!responded && m != 3 && cnt == d) begin
          responded = 1;
          i_wb_dat = (rd == 0) ? l1 : l2;
          i_wb_ack = (m != 1);
          i_wb_err = (m != 0);
        end
        cnt++;
      end
      prev_stb = o_wb_stb;
      #1;
      if (o_tlb_wsel != 0) wsel_seen = 1;
      if (o_done) begin
        got_done = 1; got_cyc = c; fin = 1;
        g_fault = o_fault; g_fsr = o_fsr; g_wsel = o_tlb_wsel;
        g_wdesc = o_tlb_wdesc; g_wdom = o_tlb_wdom; g_far = o_far;
      end else if (!o_busy) begin
        got_cyc = c; fin = 1;
      end
    end
    if (!fin) chk("walk_ended", fin, 1);
    if (flush_cyc <= 0) begin
      chk("done", got_done, 1);
      chk("latency", got_cyc, e.lat);
      chk("reads", rd + 1, e.nrd);
      chk("fault", g_fault, e.fault);
      chk("far", g_far, va);
      if (e.fault) chk("fsr", g_fsr, e.fsr);
      else begin
        chk("wsel", g_wsel, e.wsel);
        chk("wdesc", g_wdesc, e.wdesc);
        chk("wdom", g_wdom, e.wdom);
        chk("wva", o_tlb_wva, va);
      end
    end
    @(negedge i_clk);
    i_wb_ack = 0; i_wb_err = 0; i_flush = 0;
    #1;
    chk("done_pulse", {o_done, o_tlb_wsel}, 0);
    chk("idle_busy", o_busy, 0);
  endtask

  bit gd, ws;
  int gc;

  initial begin
    i_reset = 1; i_walk = 0; i_flush = 0; i_va = 0; i_ttbr = 0;
    i_wb_ack = 0; i_wb_err = 0; i_wb_dat = 0;
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_bus", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel}, 0);
    chk("rst_adr", o_wb_adr, 0);
    chk("rst_done", {o_done, o_fault, o_tlb_wsel}, 0);
    chk("rst_fsr", o_fsr, 0);
    chk("rst_far", o_far, 0);
    i_reset = 0;

    // section, coarse small, coarse L2 fault (dom 3)
    run_walk(32'h1230_0456, 32'h0000_4000, 32'h8000_0C1E, 0, 0, 0, 0, 0, -1, gd, gc, ws);
    run_walk(32'h1234_5678, 32'h0000_4000, 32'h0010_0021, 32'h0050_002E, 0, 0, 0, 0, -1, gd, gc, ws);
    run_walk(32'h0ABC_D123, 32'h0000_8000, 32'h0010_0061, 32'h0, 1, 0, 2, 0, -1, gd, gc, ws);
    // fine tiny refill, coarse tiny fault, large page
    run_walk(32'h7654_3210, 32'h1234_C000, 32'h0020_01F3, 32'h0099_9003, 0, 0, 0, 0, -1, gd, gc, ws);
    run_walk(32'h7654_3210, 32'h1234_C000, 32'h0020_01E1, 32'h0099_9003, 0, 0, 0, 0, -1, gd, gc, ws);
    run_walk(32'hFFFF_FFFC, 32'hFFFF_C000, 32'h0030_0041, 32'h0077_7001, 3, 0, 4, 0, -1, gd, gc, ws);
    // L1 err+ack, L1 timeout, L2 error, L1 section-table fault
    run_walk(32'h1111_1111, 32'h0000_4000, 32'h8000_0C1E, 0, 0, 2, 0, 0, -1, gd, gc, ws);
    run_walk(32'h2222_2222, 32'h0000_4000, 32'h8000_0C1E, 0, 0, 3, 0, 0, -1, gd, gc, ws);
    run_walk(32'h3333_3333, 32'h0000_4000, 32'h0010_00A1, 32'h0050_002E, 0, 0, 1, 1, -1, gd, gc, ws);
    run_walk(32'h4444_4444, 32'h0000_4000, 32'hDEAD_BEEC, 0, 2, 0, 0, 0, -1, gd, gc, ws);
    // walk and flush together in IDLE: accepted
    run_walk(32'h5555_5555, 32'h0000_4000, 32'h8000_0C1E, 0, 0, 0, 0, 0, 0, gd, gc, ws);

    // flush while waiting on the L2 read; ack arrives three cycles later
    run_walk(32'h1234_5678, 32'h0000_4000, 32'h0010_0021, 32'h0050_002E, 0, 0, 3, 0, 3, gd, gc, ws);
    chk("flush_l2_done", gd, 0);
    chk("flush_l2_idle_cyc", gc, 7);
    chk("flush_l2_wsel", ws, 0);
    // flush in DONE suppresses the refill
    run_walk(32'h1230_0456, 32'h0000_4000, 32'h8000_0C1E, 0, 0, 0, 0, 0, 2, gd, gc, ws);
    chk("flush_done_done", gd, 0);
    chk("flush_done_idle_cyc", gc, 3);
    chk("flush_done_wsel", ws, 0);

    // reset in the middle of the L1 read
    @(negedge i_clk);
    i_walk = 1; i_va = 32'h9999_0000; i_ttbr = 32'h0000_4000;
    @(negedge i_clk);
    i_walk = 0;
    #1 chk("pre_rst_stb", o_wb_stb, 1);
    i_reset = 1;
    #1;
    chk("mid_rst_bus", {o_wb_cyc, o_wb_stb}, 0);
    chk("mid_rst_busy", o_busy, 0);
    @(negedge i_clk);
    i_reset = 0;
    run_walk(32'h1234_5678, 32'h0000_4000, 32'h0010_0021, 32'h0050_002E, 0, 0, 0, 0, -1, gd, gc, ws);

    for (int n = 0; n < 60; n++) begin
      run_walk($urandom, $urandom, $urandom, $urandom, $urandom_range(0, 5), pick_mode(),
               $urandom_range(0, 5), pick_mode(), -1, gd, gc, ws);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
